rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback requesters:
//  A (ALU result) and B (memory load). Each requester has a one-entry holding slot.

---
 rtl/rf_wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter sharing the register-file write port between requesters A and B, with
// one-entry holding slots, round-robin/age arbitration and a pending-write scoreboard.
// Optional macro RF_ZERO_GUARD_EN: writes to R0 are accepted and silently dropped.
module rf_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              idle
);

  logic              vldA_p0;
  logic              vldB_p0;
  logic [ADDR_W-1:0] addrA_p0;
  logic [ADDR_W-1:0] addrB_p0;
  logic [DATA_W-1:0] dataA_p0;
  logic [DATA_W-1:0] dataB_p0;
  logic              bOlder;
  logic              rrPtrB;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  logic              grantA;
  logic              grantB;
  logic              rrFlip;
  logic              acceptA;
  logic              acceptB;
  logic              captureA;
  logic              captureB;
  logic              rsHit;
  logic              rtHit;

  function automatic logic addrHit(input logic              v,
                                   input logic [ADDR_W-1:0] held,
                                   input logic [ADDR_W-1:0] ra);
    return v && (held == ra);
  endfunction

  // Slot input handshake: readiness depends only on slot state and the current grant
  assign a_ready = ~vldA_p0 | grantA;
  assign b_ready = ~vldB_p0 | grantB;
  assign acceptA = a_valid & a_ready;
  assign acceptB = b_valid & b_ready;

`ifdef RF_ZERO_GUARD_EN
  assign captureA = acceptA & (a_addr != '0);
  assign captureB = acceptB & (b_addr != '0);
`else
  assign captureA = acceptA;
  assign captureB = acceptB;
`endif

  // Same-address contention must preserve write order, so age beats the pointer there
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    rrFlip = 1'b0;
    if (vldA_p0 && vldB_p0) begin
      if (addrA_p0 == addrB_p0) begin
        if (bOlder) grantB = 1'b1;
        else        grantA = 1'b1;
      end else begin
        rrFlip = 1'b1;
        if (rrPtrB) grantB = 1'b1;
        else        grantA = 1'b1;
      end
    end else if (vldA_p0) begin
      grantA = 1'b1;
    end else if (vldB_p0) begin
      grantB = 1'b1;
    end
  end

  // Stage p0: holding slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldA_p0 <= 1'b0;
      vldB_p0 <= 1'b0;
      bOlder  <= 1'b0;
      rrPtrB  <= 1'b0;
    end else begin
      vldA_p0 <= captureA | (vldA_p0 & ~grantA);
      vldB_p0 <= captureB | (vldB_p0 & ~grantB);
      if (captureB)      bOlder <= 1'b0;
      else if (captureA) bOlder <= 1'b1;
      if (rrFlip)        rrPtrB <= ~rrPtrB;
    end
  end

  always_ff @(posedge clk) begin
    if (captureA) begin
      addrA_p0 <= a_addr;
      dataA_p0 <= a_data;
    end
    if (captureB) begin
      addrB_p0 <= b_addr;
      dataB_p0 <= b_data;
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= grantA | grantB;
      if (grantA) begin
        addr_p1 <= addrA_p0;
        data_p1 <= dataA_p0;
      end else if (grantB) begin
        addr_p1 <= addrB_p0;
        data_p1 <= dataB_p0;
      end
    end
  end

  assign rf_we    = vld_p1;
  assign rf_waddr = addr_p1;
  assign rf_wdata = data_p1;
  assign idle     = ~vldA_p0 & ~vldB_p0 & ~vld_p1;

  assign rsHit = addrHit(vldA_p0, addrA_p0, rs_addr) | addrHit(vldB_p0, addrB_p0, rs_addr)
               | addrHit(vld_p1, addr_p1, rs_addr);
  assign rtHit = addrHit(vldA_p0, addrA_p0, rt_addr) | addrHit(vldB_p0, addrB_p0, rt_addr)
               | addrHit(vld_p1, addr_p1, rt_addr);

`ifdef RF_ZERO_GUARD_EN
  assign rs_busy = rsHit & (rs_addr != '0);
  assign rt_busy = rtHit & (rt_addr != '0);
`else
  assign rs_busy = rsHit;
  assign rt_busy = rtHit;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand-written ordering/reset sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef RF_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr = '0, b_addr = '0, rs_addr = '0, rt_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          rf_we, rs_busy, rt_busy, idle;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  rf_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          full;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   ts;
  } mslot_t;

  mslot_t        mA, mB;
  logic          mPtrB, mWe;
  logic [AW-1:0] mWaddr;
  logic [DW-1:0] mWdata;
  int unsigned   mEdge;

  task automatic mReset();
    mA = '0; mB = '0; mPtrB = 1'b0; mWe = 1'b0; mWaddr = '0; mWdata = '0; mEdge = 0;
  endtask

  // 0: nobody, 1: A, 2: B
  function automatic int mGrant();
    if (mA.full && mB.full) begin
      if (mA.addr == mB.addr) return (mB.ts < mA.ts) ? 2 : 1;
      return mPtrB ? 2 : 1;
    end
    if (mA.full) return 1;
    if (mB.full) return 2;
    return 0;
  endfunction

  function automatic logic mBusy(input logic [AW-1:0] ra);
    if (GUARD && ra == '0) return 1'b0;
    return (mA.full && mA.addr == ra) || (mB.full && mB.addr == ra) || (mWe && mWaddr == ra);
  endfunction

  task automatic mClock();
    int   g;
    logic capA, capB;
    g    = mGrant();
    capA = a_valid && (!mA.full || g == 1) && !(GUARD && a_addr == '0);
    capB = b_valid && (!mB.full || g == 2) && !(GUARD && b_addr == '0);
    mWe  = (g != 0);
    if (g == 1) begin mWaddr = mA.addr; mWdata = mA.data; end
    if (g == 2) begin mWaddr = mB.addr; mWdata = mB.data; end
    if (mA.full && mB.full && mA.addr != mB.addr) mPtrB = !mPtrB;
    if (g == 1) mA.full = 1'b0;
    if (g == 2) mB.full = 1'b0;
    if (capA) mA = '{full: 1'b1, addr: a_addr, data: a_data, ts: mEdge};
    if (capB) mB = '{full: 1'b1, addr: b_addr, data: b_data, ts: mEdge};
    mEdge++;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic aV; logic [AW-1:0] aA; logic [DW-1:0] aD;
    logic bV; logic [AW-1:0] bA; logic [DW-1:0] bD;
    logic [AW-1:0] rs; logic [AW-1:0] rt;
    logic eAR; logic eBR; logic eWe; logic [AW-1:0] eWa; logic [DW-1:0] eWd;
    logic eRs; logic eRt; logic eIdle;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mkv(input logic aV, input logic [AW-1:0] aA, input logic [DW-1:0] aD,
                               input logic bV, input logic [AW-1:0] bA, input logic [DW-1:0] bD,
                               input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                               input logic eAR, input logic eBR, input logic eWe,
                               input logic [AW-1:0] eWa, input logic [DW-1:0] eWd,
                               input logic eRs, input logic eRt, input logic eIdle);
    return '{aV, aA, aD, bV, bA, bD, rs, rt, eAR, eBR, eWe, eWa, eWd, eRs, eRt, eIdle};
  endfunction

  task automatic doReset();
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    mReset();
  endtask

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           wq[$];
  wr_t           expW [3];
  logic [DW-1:0] rfImg [32];

  initial begin
    // Single A write, then two contention rounds, then the R0 case
    vecs[0]  = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd5,5'd6, 1'b1,1'b1,1'b0,5'd0,32'h0,        1'b0,1'b0,1'b1);
    vecs[1]  = mkv(1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0, 5'd5,5'd6, 1'b1,1'b1,1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1);
    vecs[2]  = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd5,5'd6, 1'b1,1'b1,1'b0,5'd0,32'h0,        1'b1,1'b0,1'b0);
    vecs[3]  = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd5,5'd6, 1'b1,1'b1,1'b1,5'd5,32'hDEADBEEF, 1'b1,1'b0,1'b0);
    vecs[4]  = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd5,5'd6, 1'b1,1'b1,1'b0,5'd5,32'hDEADBEEF, 1'b0,1'b0,1'b1);
    vecs[5]  = mkv(1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 5'd3,5'd4, 1'b1,1'b1,1'b0,5'd5,32'hDEADBEEF, 1'b0,1'b0,1'b1);
    vecs[6]  = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd3,5'd4, 1'b1,1'b0,1'b0,5'd5,32'hDEADBEEF, 1'b1,1'b1,1'b0);
    vecs[7]  = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd3,5'd4, 1'b1,1'b1,1'b1,5'd3,32'h11,        1'b1,1'b1,1'b0);
    vecs[8]  = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd3,5'd4, 1'b1,1'b1,1'b1,5'd4,32'h22,        1'b0,1'b1,1'b0);
    vecs[9]  = mkv(1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 5'd3,5'd4, 1'b1,1'b1,1'b0,5'd4,32'h22,      1'b0,1'b0,1'b1);
    vecs[10] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd3,5'd4, 1'b0,1'b1,1'b0,5'd4,32'h22,        1'b1,1'b1,1'b0);
    vecs[11] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd3,5'd4, 1'b1,1'b1,1'b1,5'd4,32'h22,        1'b1,1'b1,1'b0);
    vecs[12] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd3,5'd4, 1'b1,1'b1,1'b1,5'd3,32'h11,        1'b1,1'b0,1'b0);
    vecs[13] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd3,5'd4, 1'b1,1'b1,1'b0,5'd3,32'h11,        1'b0,1'b0,1'b1);
    vecs[14] = mkv(1'b1,5'd0,32'h55, 1'b0,5'd0,32'h0, 5'd0,5'd4, 1'b1,1'b1,1'b0,5'd3,32'h11,       1'b0,1'b0,1'b1);
`ifdef RF_ZERO_GUARD_EN
    vecs[15] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd0,5'd4, 1'b1,1'b1,1'b0,5'd3,32'h11,        1'b0,1'b0,1'b1);
    vecs[16] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd0,5'd4, 1'b1,1'b1,1'b0,5'd3,32'h11,        1'b0,1'b0,1'b1);
    vecs[17] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd0,5'd4, 1'b1,1'b1,1'b0,5'd3,32'h11,        1'b0,1'b0,1'b1);
`else
    vecs[15] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd0,5'd4, 1'b1,1'b1,1'b0,5'd3,32'h11,        1'b1,1'b0,1'b0);
    vecs[16] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd0,5'd4, 1'b1,1'b1,1'b1,5'd0,32'h55,        1'b1,1'b0,1'b0);
    vecs[17] = mkv(1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 5'd0,5'd4, 1'b1,1'b1,1'b0,5'd0,32'h55,        1'b0,1'b0,1'b1);
`endif

    doReset();
    for (int i = 0; i < NV; i++) begin
      a_valid = vecs[i].aV; a_addr = vecs[i].aA; a_data = vecs[i].aD;
      b_valid = vecs[i].bV; b_addr = vecs[i].bA; b_data = vecs[i].bD;
      rs_addr = vecs[i].rs; rt_addr = vecs[i].rt;
      @(negedge clk);
      chkb($sformatf("vec%0d.a_ready", i), a_ready, vecs[i].eAR);
      chkb($sformatf("vec%0d.b_ready", i), b_ready, vecs[i].eBR);
      chkb($sformatf("vec%0d.rf_we", i), rf_we, vecs[i].eWe);
      chka($sformatf("vec%0d.rf_waddr", i), rf_waddr, vecs[i].eWa);
      chkd($sformatf("vec%0d.rf_wdata", i), rf_wdata, vecs[i].eWd);
      chkb($sformatf("vec%0d.rs_busy", i), rs_busy, vecs[i].eRs);
      chkb($sformatf("vec%0d.rt_busy", i), rt_busy, vecs[i].eRt);
      chkb($sformatf("vec%0d.idle", i), idle, vecs[i].eIdle);
      @(posedge clk);
      #1;
    end

    // Same-address ordering: B is older than the refilled A while the pointer still favours A
    doReset();
    for (int i = 0; i < 32; i++) rfImg[i] = '0;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB;
    @(posedge clk);
    #1;
    chkb("order.a_ready_refill", a_ready, 1'b1);
    chkb("order.b_ready_blocked", b_ready, 1'b0);
    a_data = 32'hA;
    b_valid = 1'b0;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    wq.delete();
    for (int c = 0; c < 4; c++) begin
      if (rf_we) begin
        wq.push_back('{a: rf_waddr, d: rf_wdata});
        rfImg[rf_waddr] = rf_wdata;
      end
      @(posedge clk);
      #1;
    end
    expW[0] = '{a: 5'd7, d: 32'h1};
    expW[1] = '{a: 5'd7, d: 32'hB};
    expW[2] = '{a: 5'd7, d: 32'hA};
    chkd("order.write_count", 32'(wq.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < wq.size()) begin
        chka($sformatf("order.w%0d.addr", k), wq[k].a, expW[k].a);
        chkd($sformatf("order.w%0d.data", k), wq[k].d, expW[k].d);
      end
    end
    chkd("order.R7_final", rfImg[7], 32'hA);

    // Reset while a write is on the port and slot B still holds data
    doReset();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    rs_addr = 5'd4; rt_addr = 5'd3;
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0;
    chkb("rstmid.idle_loaded", idle, 1'b0);
    @(posedge clk);
    #1;
    chkb("rstmid.we_before", rf_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chkb("rstmid.rf_we", rf_we, 1'b0);
    chka("rstmid.rf_waddr", rf_waddr, 5'd0);
    chkd("rstmid.rf_wdata", rf_wdata, 32'h0);
    chkb("rstmid.idle", idle, 1'b1);
    chkb("rstmid.a_ready", a_ready, 1'b1);
    chkb("rstmid.b_ready", b_ready, 1'b1);
    chkb("rstmid.rs_busy", rs_busy, 1'b0);
    chkb("rstmid.rt_busy", rt_busy, 1'b0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chkb($sformatf("rstmid.post%0d.rf_we", c), rf_we, 1'b0);
      chkb($sformatf("rstmid.post%0d.idle", c), idle, 1'b1);
    end

    // Randomized traffic on a small address space to force collisions
    doReset();
    for (int c = 0; c < 2000; c++) begin
      a_valid = ($urandom_range(0, 9) < 6);
      a_addr  = 5'($urandom_range(0, 7));
      a_data  = $urandom();
      b_valid = ($urandom_range(0, 9) < 6);
      b_addr  = 5'($urandom_range(0, 7));
      b_data  = $urandom();
      rs_addr = 5'($urandom_range(0, 7));
      rt_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
      chkb($sformatf("rnd%0d.a_ready", c), a_ready, !mA.full || mGrant() == 1);
      chkb($sformatf("rnd%0d.b_ready", c), b_ready, !mB.full || mGrant() == 2);
      chkb($sformatf("rnd%0d.rf_we", c), rf_we, mWe);
      chka($sformatf("rnd%0d.rf_waddr", c), rf_waddr, mWaddr);
      chkd($sformatf("rnd%0d.rf_wdata", c), rf_wdata, mWdata);
      chkb($sformatf("rnd%0d.rs_busy", c), rs_busy, mBusy(rs_addr));
      chkb($sformatf("rnd%0d.rt_busy", c), rt_busy, mBusy(rt_addr));
      chkb($sformatf("rnd%0d.idle", c), idle, !mA.full && !mB.full && !mWe);
      mClock();
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
